// File: rtl/prog_loader_if.sv
// Byte-stream / instruction-memory write bundle between the program source and prog_loader.
// master drives the byte stream; slave is the loader that writes the memory and gates the CPU.
interface prog_loader_if #(
  parameter int D = 12,
  parameter int W = 9
);
  logic         load_req;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         start;
  logic         loaded;
  logic         err;

  modport master (
    output load_req, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, start, loaded, err
  );

  modport slave (
    input  load_req, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, start, loaded, err
  );
endinterface

// File: rtl/prog_loader.sv
// Length-prefixed byte-stream loader: packs byte pairs into 9-bit words, writes instruction
// memory, and holds the CPU in start until the last write has landed.
module prog_loader #(
  parameter int D = 12,
  parameter int W = 9
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, INS_LO, INS_HI, LAST, DONE, ERR} state_t;

  localparam logic [16:0] MAX_N = 17'(1) << D;

  state_t       state, state_nx;
  logic [15:0]  cnt;
  logic [D:0]   idx;
  logic [7:0]   lo_byte;
  logic         wr_en_q;
  logic [D-1:0] wr_addr_q;
  logic [W-1:0] wr_data_q;

  logic         ready, xfer;
  logic [15:0]  cnt_nx;
  logic [16:0]  idx_inc;
  logic         ld_cnt_lo, ld_cnt_hi, ld_lo, do_write, clr_idx;

  assign ready   = (state == CNT_LO) || (state == CNT_HI) ||
                   (state == INS_LO) || (state == INS_HI);
  assign xfer    = bus.byte_valid && ready;
  assign cnt_nx  = {bus.byte_in, cnt[7:0]};
  assign idx_inc = 17'(idx) + 17'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ld_cnt_lo = 1'b0;
    ld_cnt_hi = 1'b0;
    ld_lo     = 1'b0;
    do_write  = 1'b0;
    clr_idx   = 1'b0;
    // A restart wins over any byte moving on the same edge; that byte is dropped.
    if (bus.load_req) begin
      state_nx = CNT_LO;
      clr_idx  = 1'b1;
    end else begin
      case (state)
        CNT_LO: if (xfer) begin
          ld_cnt_lo = 1'b1;
          state_nx  = CNT_HI;
        end
        CNT_HI: if (xfer) begin
          ld_cnt_hi = 1'b1;
          if (cnt_nx == 16'd0)                state_nx = DONE;
          else if ({1'b0, cnt_nx} > MAX_N)    state_nx = ERR;
          else                                state_nx = INS_LO;
        end
        INS_LO: if (xfer) begin
          ld_lo    = 1'b1;
          state_nx = INS_HI;
        end
        INS_HI: if (xfer) begin
          if (|bus.byte_in[7:1]) state_nx = ERR;
          else begin
            do_write = 1'b1;
            state_nx = (idx_inc == {1'b0, cnt}) ? LAST : INS_LO;
          end
        end
        LAST:    state_nx = DONE;
        IDLE, DONE, ERR: state_nx = state;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      idx       <= '0;
      lo_byte   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= do_write;
      if (ld_cnt_lo) cnt[7:0]  <= bus.byte_in;
      if (ld_cnt_hi) cnt[15:8] <= bus.byte_in;
      if (ld_lo)     lo_byte   <= bus.byte_in;
      if (clr_idx) idx <= '0;
      else if (do_write) begin
        idx       <= idx + 1'b1;
        wr_addr_q <= idx[D-1:0];
        wr_data_q <= {bus.byte_in[0], lo_byte};
      end
    end
  end

  assign bus.byte_ready = ready;
  assign bus.start      = (state != DONE);
  assign bus.loaded     = (state == DONE);
  assign bus.err        = (state == ERR);
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;

endmodule

// File: tb/tb_prog_loader.sv
// Random and directed frames for prog_loader, scored against a frame-parsing reference model.
module tb_prog_loader;
  localparam int D = 12;
  localparam int K_DONE = 0, K_ERR = 1, K_PART = 2;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nvec = 0, nerr = 0;
  int   exp_q[$];
  int   obs_q[$];

  prog_loader_if #(.D(D), .W(9)) ifc ();
  prog_loader #(.D(D), .W(9)) dut (.clk(clk), .reset(reset), .bus(ifc));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (ifc.wr_en) obs_q.push_back((int'(ifc.wr_addr) << 9) | int'(ifc.wr_data));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: parse the frame by its format rules; append expected writes to exp_q.
  task automatic model(input bq_t b, output int kind, output int acc, output int n);
    logic [7:0] hi, lo;
    kind = K_PART; acc = b.size(); n = 0;
    if (b.size() < 2) return;
    n = int'({b[1], b[0]});
    if (n == 0)      begin kind = K_DONE; acc = 2; return; end
    if (n > (1 << D)) begin kind = K_ERR;  acc = 2; return; end
    for (int i = 0; i < n; i++) begin
      if (3 + 2*i >= b.size()) return;
      lo = b[2 + 2*i];
      hi = b[3 + 2*i];
      if (hi[7:1] != 7'd0) begin kind = K_ERR; acc = 4 + 2*i; return; end
      exp_q.push_back((i << 9) | int'({hi[0], lo}));
    end
    kind = K_DONE; acc = 2 + 2*n;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int bound;
    @(negedge clk);
    if (gaps)
      while ($urandom_range(0, 2) == 0) begin
        ifc.byte_valid = 1'b0;
        ifc.byte_in = 8'($urandom);
        @(negedge clk);
      end
    ifc.byte_valid = 1'b1;
    ifc.byte_in = b;
    bound = 0;
    while (!ifc.byte_ready && bound < 50) begin @(negedge clk); bound++; end
    if (!ifc.byte_ready) chk("ready_timeout", ifc.byte_ready, 1);
    @(posedge clk); #1;
    ifc.byte_valid = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, ".nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s.wr[%0d]", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_frame(input string tag, input bq_t b, input bit gaps, input bit junk);
    int kind, acc, n;
    model(b, kind, acc, n);
    @(negedge clk);
    ifc.load_req = 1'b1;
    if (junk) begin ifc.byte_valid = 1'b1; ifc.byte_in = 8'h77; end
    @(posedge clk); #1;
    ifc.load_req = 1'b0;
    ifc.byte_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".ready_rise"}, ifc.byte_ready, 1);
    for (int i = 0; i < acc; i++) send_byte(b[i], gaps);
    if (kind == K_DONE && n > 0) begin
      @(negedge clk);
      chk({tag, ".last_wr_en"}, ifc.wr_en, 1);
      chk({tag, ".last_start"}, ifc.start, 1);
      chk({tag, ".last_loaded"}, ifc.loaded, 0);
      @(negedge clk);
      chk({tag, ".done_start"}, ifc.start, 0);
      chk({tag, ".done_loaded"}, ifc.loaded, 1);
      chk({tag, ".done_err"}, ifc.err, 0);
      chk({tag, ".done_ready"}, ifc.byte_ready, 0);
    end else if (kind == K_DONE) begin
      @(negedge clk);
      chk({tag, ".empty_start"}, ifc.start, 0);
      chk({tag, ".empty_loaded"}, ifc.loaded, 1);
      chk({tag, ".empty_wr_en"}, ifc.wr_en, 0);
    end else if (kind == K_ERR) begin
      @(negedge clk);
      chk({tag, ".err"}, ifc.err, 1);
      chk({tag, ".err_start"}, ifc.start, 1);
      chk({tag, ".err_loaded"}, ifc.loaded, 0);
      chk({tag, ".err_ready"}, ifc.byte_ready, 0);
    end
    repeat (2) @(negedge clk);
    compare_writes(tag);
  endtask

  initial begin
    bq_t f;
    int  n;
    ifc.load_req = 1'b0;
    ifc.byte_in = 8'h00;
    ifc.byte_valid = 1'b0;
    #3;
    chk("rst.start", ifc.start, 1);
    chk("rst.ready", ifc.byte_ready, 0);
    chk("rst.wr_en", ifc.wr_en, 0);
    chk("rst.loaded", ifc.loaded, 0);
    chk("rst.err", ifc.err, 0);
    chk("rst.wr_addr", ifc.wr_addr, 0);
    chk("rst.wr_data", ifc.wr_data, 0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle.ready", ifc.byte_ready, 0);
    chk("idle.start", ifc.start, 1);

    run_frame("basic", '{8'h03, 8'h00, 8'h12, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h01}, 0, 0);
    run_frame("bp",    '{8'h03, 8'h00, 8'h12, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h01}, 1, 0);
    run_frame("empty", '{8'h00, 8'h00}, 0, 0);
    run_frame("badhi", '{8'h01, 8'h00, 8'h34, 8'h02}, 0, 0);
    run_frame("bign",  '{8'h01, 8'h10}, 0, 0);
    run_frame("recov", '{8'h02, 8'h00, 8'hA5, 8'h01, 8'h5A, 8'h00}, 0, 0);

    // Restart after 5 bytes; the byte riding the load_req edge must be discarded.
    run_frame("part",    '{8'h03, 8'h00, 8'h12, 8'h00, 8'hFF}, 0, 0);
    run_frame("restart", '{8'h02, 8'h00, 8'hAA, 8'h01, 8'h55, 8'h00}, 0, 1);

    // Asynchronous reset mid-frame.
    run_frame("prerst", '{8'h03, 8'h00, 8'h12, 8'h00, 8'hFF}, 0, 0);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midrst.start", ifc.start, 1);
    chk("midrst.ready", ifc.byte_ready, 0);
    chk("midrst.wr_en", ifc.wr_en, 0);
    chk("midrst.loaded", ifc.loaded, 0);
    chk("midrst.wr_data", ifc.wr_data, 0);
    @(negedge clk); reset = 1'b0;
    ifc.byte_valid = 1'b1; ifc.byte_in = 8'h01;
    repeat (3) @(negedge clk);
    ifc.byte_valid = 1'b0;
    chk("postrst.ready", ifc.byte_ready, 0);
    chk("postrst.start", ifc.start, 1);
    compare_writes("postrst");

    // Largest legal image: 2^D words.
    f = '{8'h00, 8'h10};
    for (int i = 0; i < (1 << D); i++) begin
      f.push_back(8'($urandom));
      f.push_back(8'($urandom_range(0, 1)));
    end
    run_frame("maxn", f, 0, 0);

    for (int it = 0; it < 24; it++) begin
      f.delete();
      n = ($urandom_range(0, 9) == 0) ? 4097 + $urandom_range(0, 60000) : $urandom_range(0, 6);
      f.push_back(n[7:0]);
      f.push_back(n[15:8]);
      for (int i = 0; i < n && i < 8; i++) begin
        f.push_back(8'($urandom));
        if ($urandom_range(0, 9) == 0) f.push_back(8'($urandom) | 8'h02);
        else                           f.push_back(8'($urandom_range(0, 1)));
      end
      run_frame($sformatf("rnd%0d", it), f, bit'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader for the single-cycle 9-bit CPU. It receives a length-prefixed instruction image over a valid/ready byte interface. It packs each pair of bytes into a 9-bit machine word and writes it into the instruction memory's write port. It holds the CPU's `start` high for the whole load and releases it one cycle after the last write lands, so the CPU begins fetching at address 0 from a complete image.

## Interface
Parameters:
- `D`, 12: instruction-memory address width; matches the PC width. Maximum image length is 2^D words.
- `W`, 9: machine-code width. Fixed at 9; the packing rules below depend on it.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load_req`  in  1  begin a new load; sampled on the rising edge.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader can accept a byte.
- `wr_en`  out  1  instruction-memory write strobe.
- `wr_addr`  out  D  instruction-memory write address.
- `wr_data`  out  9  instruction word to write.
- `start`  out  1  to the CPU; high means hold the PC at `start_address`.
- `loaded`  out  1  image complete; CPU released.
- `err`  out  1  sticky format error.

## Operation
- **Transfer rule.** A byte transfers on a rising edge where `byte_valid && byte_ready`.
- **Frame format.**
  - Bytes 0-1: count N as 16 bits, little-endian (first byte = N[7:0]).
  - Then N words of 2 bytes each:
    - Low byte → `mach_code[7:0]`.
    - High byte bit 0 → `mach_code[8]`.
    - High byte bits [7:1] must be 0.
- **States:** IDLE, CNT_LO, CNT_HI, INS_LO, INS_HI, LAST, DONE, ERR.
- **Decoded outputs.** All outputs below are decoded from the state register only, with no combinational path from inputs:
  - `byte_ready` = 1 in CNT_LO, CNT_HI, INS_LO, INS_HI.
  - `start` = 0 only in DONE.
  - `loaded` = 1 only in DONE.
  - `err` = 1 only in ERR.
- **State transitions:**
  - IDLE / DONE / ERR: on `load_req` → CNT_LO; word index cleared to 0.
  - CNT_LO: on transfer, latch N[7:0] → CNT_HI.
  - CNT_HI: on transfer, latch N[15:8], then:
    - N == 0 → DONE.
    - N > 2^D → ERR.
    - Otherwise → INS_LO.
  - INS_LO: on transfer, latch the low byte → INS_HI.
  - INS_HI: on transfer:
    - If bits [7:1] ≠ 0 → ERR, with no write.
    - Otherwise register `wr_en`=1, `wr_addr`=index, `wr_data`={bit0, low byte}, and increment index.
    - Next state is LAST if index+1 == N, else INS_LO.
  - LAST: unconditional → DONE. The final `wr_en` pulse is visible during LAST.
- **`load_req` priority.** `load_req` in any non-IDLE state also restarts to CNT_LO with the index cleared. A byte transferring on that same edge is discarded, and no write is issued from it.
- **Write strobe.** `wr_en` is a registered 1-cycle pulse, issued exactly once per accepted word. It is 0 in every other cycle. `wr_addr` and `wr_data` hold their last values between pulses.
- **Counter widths.** The word index is D+1 bits, so N = 2^D is representable. `wr_addr` takes the low D bits of the index, and the index never wraps within a legal frame.
- **Reset values.** State = IDLE, `byte_ready`=0, `start`=1, `loaded`=0, `err`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, index=0, N=0.
- **Reset mid-load.** Asynchronous reset mid-load returns to these values immediately. A partial image left in memory is not cleared.

## Timing
- `byte_ready` rises the cycle after `load_req` is sampled.
- The write for a word appears in the cycle after the edge that accepted its high byte. Latency is 1 cycle from the accepting edge.
- After the last high byte is accepted:
  - cycle +1: LAST, with `wr_en`=1 and `start`=1.
  - cycle +2: DONE, with `start`=0 and `loaded`=1.
  - Memory therefore has captured the last word before the CPU samples `start` low.
- N = 0: `start` falls the cycle after the CNT_HI acceptance edge, with no writes.
- Throughput is 1 byte/cycle when `byte_valid` is held high, so N words take 2N+2 accept cycles plus 1 (LAST).
- Gaps in `byte_valid` stall the state machine with no side effects.
- In ERR, `start` stays 1, so the CPU is held. Only `load_req` or `reset` leaves ERR.

## Test plan
- **Reset.** Assert `reset` mid-cycle → outputs immediately `start`=1, `byte_ready`=0, `wr_en`=0, `loaded`=0, `err`=0. Deassert → outputs stay in IDLE until `load_req`.
- **Basic load.** `load_req`, then bytes 03 00 12 00 FF 01 00 01 back-to-back → exactly three `wr_en` pulses: (0,0x012), (1,0x1FF), (2,0x100). `start` falls 2 cycles after the 8th byte is accepted, and `loaded`=1.
- **Backpressure.** Same frame with `byte_valid` toggled 1-0-1 at random → identical writes, no duplicates, and no writes while `byte_valid`=0.
- **Empty image.** Frame 00 00 → no `wr_en`, DONE reached the cycle after the second byte, `start`=0.
- **Format errors.**
  - Frame 01 00 34 02 → ERR, `err`=1, no write, `start`=1.
  - Frame 01 10 (N=4097, D=12) → ERR after the second byte.
  - Then `load_req` followed by a valid frame → normal load; `err` clears.
- **Restart and reset mid-load.**
  - `load_req` asserted after the 5th byte of a 3-word frame → index restarts at 0. The next 2 bytes are taken as the count, and the new frame's writes begin at address 0.
  - `reset` asserted mid-frame → immediate IDLE, no further writes.
